proc_control_fsm: RTL and testbench

//  Moore FSM that sequences the 16-bit processor datapath: PC, instruction ROM/IR, data RAM, regfile, ALU.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/proc_control_fsm.sv | 149 ++++++++++++++
 tb/tb_proc_control_fsm.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the processor control FSM.
// State/opcode encodings, ALU select codes and IR field positions.
package proc_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_STORE = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_HALT  = 4'b0101
  } opcode_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam int IR_W     = 16;
  localparam int OPC_LSB  = 12;
  localparam int DADR_LSB = 4;
  localparam int RA_LSB   = 8;
  localparam int RB_LSB   = 4;
  localparam int RD_LSB   = 0;

  // Opcodes above HALT are unassigned.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_HALT);
  endfunction

endpackage

// File: rtl/proc_control_fsm.sv
// Moore control FSM sequencing the 16-bit processor datapath (Fetch-Decode-Execute).
// Optional feature: ILLEGAL_TRAP_EN traps unassigned opcodes into HALT with Fault set.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4,
  parameter int ALUS_W  = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [IR_W-1:0]    IR,
  output logic               PC_Clr,
  output logic               PC_Up,
  output logic               IR_Ld,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] RF_W_Addr,
  output logic               RF_W_en,
  output logic [RADDR_W-1:0] RF_Ra_Addr,
  output logic [RADDR_W-1:0] RF_Rb_Addr,
  output logic [ALUS_W-1:0]  ALU_s0,
  output logic [3:0]         State,
  output logic [3:0]         NextState,
  output logic               Halted,
  output logic               Fault
);

  state_t state_q, state_d;
  logic [3:0] opcode;

  assign opcode = IR[OPC_LSB +: 4];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = ST_NOOP;
          OP_STORE: state_d = ST_STORE;
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
          default:  state_d = ST_HALT;
`else
          default:  state_d = ST_NOOP;
`endif
        endcase
      end
      ST_NOOP:   state_d = ST_FETCH;
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_FETCH;
      ST_STORE:  state_d = ST_FETCH;
      ST_ADD:    state_d = ST_FETCH;
      ST_SUB:    state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic fault_q, fault_d;

  // Sticky until Reset: HALT alone cannot tell a trap from a HALT opcode.
  always_comb begin
    fault_d = fault_q;
    if (state_q == ST_DECODE && !is_legal_op(opcode)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  // Outputs depend on state_q only; IR fields are steered through per state.
  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = '0;
    Halted     = 1'b0;
    case (state_q)
      ST_INIT:  PC_Clr = 1'b1;
      ST_FETCH: begin
        IR_Ld = 1'b1;
        PC_Up = 1'b1;
      end
      ST_STORE: begin
        D_Addr     = IR[DADR_LSB +: DADDR_W];
        RF_Ra_Addr = IR[RD_LSB +: RADDR_W];
        D_Wr       = 1'b1;
      end
      ST_LOAD_A: begin
        D_Addr    = IR[DADR_LSB +: DADDR_W];
        RF_s      = 1'b1;
        RF_W_Addr = IR[RD_LSB +: RADDR_W];
      end
      ST_LOAD_B: begin
        D_Addr    = IR[DADR_LSB +: DADDR_W];
        RF_s      = 1'b1;
        RF_W_Addr = IR[RD_LSB +: RADDR_W];
        RF_W_en   = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_Addr = IR[RA_LSB +: RADDR_W];
        RF_Rb_Addr = IR[RB_LSB +: RADDR_W];
        RF_W_Addr  = IR[RD_LSB +: RADDR_W];
        ALU_s0     = (state_q == ST_ADD) ? ALUS_W'(ALU_ADD) : ALUS_W'(ALU_SUB);
        RF_W_en    = 1'b1;
      end
      ST_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign State     = state_q;
  assign NextState = state_d;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed testbench for proc_control_fsm; expected values are hand-derived constants.
// Honors ILLEGAL_TRAP_EN in the illegal-opcode scenario.
module tb_proc_control_fsm;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_en, Halted, Fault;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State, NextState;
  logic [2:0]  ALU_s0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  proc_control_fsm dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_Clr(PC_Clr), .PC_Up(PC_Up), .IR_Ld(IR_Ld),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en),
    .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
    .ALU_s0(ALU_s0), .State(State), .NextState(NextState),
    .Halted(Halted), .Fault(Fault)
  );

  task automatic step();
    @(negedge Clk);
  endtask

  // Leaves the DUT in INIT (sampled) with Reset released for the next edge.
  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    IR = 16'h0000;
    do_reset();
    n_checks++;
    if (State !== 4'd0 || PC_Clr !== 1'b1 || NextState !== 4'd1 || IR_Ld !== 1'b0 ||
        PC_Up !== 1'b0 || D_Wr !== 1'b0 || RF_W_en !== 1'b0 || Halted !== 1'b0 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: State=%0d PC_Clr=%b NextState=%0d IR_Ld=%b PC_Up=%b D_Wr=%b RF_W_en=%b Halted=%b Fault=%b, need 0 1 1 0 0 0 0 0 0",
               State, PC_Clr, NextState, IR_Ld, PC_Up, D_Wr, RF_W_en, Halted, Fault);
    end
    step();
    n_checks++;
    if (State !== 4'd1 || IR_Ld !== 1'b1 || PC_Up !== 1'b1 || PC_Clr !== 1'b0 || NextState !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_fetch: State=%0d IR_Ld=%b PC_Up=%b PC_Clr=%b NextState=%0d, need 1 1 1 0 2",
               State, IR_Ld, PC_Up, PC_Clr, NextState);
    end
    $display("reset: INIT then FETCH observed");
  endtask

  task automatic test_load();
    IR = 16'h2A53;
    do_reset();
    step(); // FETCH
    step(); // DECODE
    n_checks++;
    if (State !== 4'd2 || NextState !== 4'd4 || D_Addr !== 8'h00 || RF_W_en !== 1'b0) begin
      n_fail++;
      $display("FAIL load_decode: State=%0d NextState=%0d D_Addr=%h RF_W_en=%b, need 2 4 00 0",
               State, NextState, D_Addr, RF_W_en);
    end
    step();
    n_checks++;
    if (State !== 4'd4 || D_Addr !== 8'hA5 || RF_s !== 1'b1 || RF_W_Addr !== 4'd3 || RF_W_en !== 1'b0) begin
      n_fail++;
      $display("FAIL load_a: State=%0d D_Addr=%h RF_s=%b RF_W_Addr=%0d RF_W_en=%b, need 4 a5 1 3 0",
               State, D_Addr, RF_s, RF_W_Addr, RF_W_en);
    end
    step();
    n_checks++;
    if (State !== 4'd5 || D_Addr !== 8'hA5 || RF_s !== 1'b1 || RF_W_Addr !== 4'd3 || RF_W_en !== 1'b1) begin
      n_fail++;
      $display("FAIL load_b: State=%0d D_Addr=%h RF_s=%b RF_W_Addr=%0d RF_W_en=%b, need 5 a5 1 3 1",
               State, D_Addr, RF_s, RF_W_Addr, RF_W_en);
    end
    step();
    n_checks++;
    if (State !== 4'd1 || RF_W_en !== 1'b0 || IR_Ld !== 1'b1) begin
      n_fail++;
      $display("FAIL load_return: State=%0d RF_W_en=%b IR_Ld=%b, need 1 0 1", State, RF_W_en, IR_Ld);
    end
    $display("load 2A53: sequence 1,2,4,5,1 checked");
  endtask

  task automatic test_alu(input logic [15:0] ir, input logic [3:0] st, input logic [2:0] sel,
                          input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
    IR = ir;
    do_reset();
    step();
    step();
    n_checks++;
    if (NextState !== st) begin
      n_fail++;
      $display("FAIL alu_decode %h: NextState=%0d, need %0d", ir, NextState, st);
    end
    step();
    n_checks++;
    if (State !== st || ALU_s0 !== sel || RF_Ra_Addr !== ra || RF_Rb_Addr !== rb ||
        RF_W_Addr !== rd || RF_W_en !== 1'b1 || RF_s !== 1'b0 || D_Wr !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_exec %h: State=%0d ALU_s0=%0d Ra=%0d Rb=%0d Rd=%0d W_en=%b RF_s=%b D_Wr=%b, need %0d %0d %0d %0d %0d 1 0 0",
               ir, State, ALU_s0, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, RF_W_en, RF_s, D_Wr, st, sel, ra, rb, rd);
    end
    step();
    n_checks++;
    if (State !== 4'd1 || RF_W_en !== 1'b0 || ALU_s0 !== 3'd0) begin
      n_fail++;
      $display("FAIL alu_return %h: State=%0d RF_W_en=%b ALU_s0=%0d, need 1 0 0", ir, State, RF_W_en, ALU_s0);
    end
    $display("alu %h: state %0d sel %0d checked", ir, st, sel);
  endtask

  task automatic test_store();
    int wr_cycles;
    IR = 16'h1C07;
    do_reset();
    wr_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (D_Wr === 1'b1) begin
        wr_cycles++;
        n_checks++;
        if (State !== 4'd6 || D_Addr !== 8'hC0 || RF_Ra_Addr !== 4'd7 || RF_W_en !== 1'b0) begin
          n_fail++;
          $display("FAIL store_exec: State=%0d D_Addr=%h RF_Ra_Addr=%0d RF_W_en=%b, need 6 c0 7 0",
                   State, D_Addr, RF_Ra_Addr, RF_W_en);
        end
      end
    end
    // Four cycles span FETCH, DECODE, STORE, FETCH.
    n_checks++;
    if (wr_cycles != 1 || State !== 4'd1) begin
      n_fail++;
      $display("FAIL store_count: D_Wr cycles=%0d State=%0d, need 1 1", wr_cycles, State);
    end
    $display("store 1C07: %0d write cycle(s)", wr_cycles);
  endtask

  task automatic test_noop();
    IR = 16'h0000;
    do_reset();
    step();
    step();
    step();
    n_checks++;
    if (State !== 4'd3 || NextState !== 4'd1 || RF_W_en !== 1'b0 || D_Wr !== 1'b0) begin
      n_fail++;
      $display("FAIL noop: State=%0d NextState=%0d RF_W_en=%b D_Wr=%b, need 3 1 0 0", State, NextState, RF_W_en, D_Wr);
    end
    $display("noop 0000: checked");
  endtask

  task automatic test_halt();
    int bad;
    IR = 16'h5000;
    do_reset();
    step();
    step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (State !== 4'd9 || Halted !== 1'b1 || Fault !== 1'b0 || NextState !== 4'd9) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_hold: %0d of 20 cycles wrong, last State=%0d Halted=%b Fault=%b, need 9 1 0",
               bad, State, Halted, Fault);
    end
    Reset = 1'b1;
    step();
    n_checks++;
    if (State !== 4'd0 || Halted !== 1'b0 || PC_Clr !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset: State=%0d Halted=%b PC_Clr=%b, need 0 0 1", State, Halted, PC_Clr);
    end
    $display("halt 5000: held 20 cycles, reset to INIT");
  endtask

  task automatic test_illegal();
    IR = 16'hF000;
    do_reset();
    step();
    step();
    step();
`ifdef ILLEGAL_TRAP_EN
    n_checks++;
    if (State !== 4'd9 || Halted !== 1'b1 || Fault !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_trap: State=%0d Halted=%b Fault=%b, need 9 1 1", State, Halted, Fault);
    end
    step();
    step();
    n_checks++;
    if (State !== 4'd9 || Fault !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_hold: State=%0d Fault=%b, need 9 1", State, Fault);
    end
    Reset = 1'b1;
    step();
    n_checks++;
    if (State !== 4'd0 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: State=%0d Fault=%b, need 0 0", State, Fault);
    end
`else
    n_checks++;
    if (State !== 4'd3 || Fault !== 1'b0 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_noop: State=%0d Fault=%b Halted=%b, need 3 0 0", State, Fault, Halted);
    end
    step();
    n_checks++;
    if (State !== 4'd1 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_return: State=%0d Fault=%b, need 1 0", State, Fault);
    end
`endif
    $display("illegal F000: checked");
  endtask

  task automatic test_reset_mid_load();
    IR = 16'h2A53;
    do_reset();
    step();
    step();
    step();
    n_checks++;
    if (State !== 4'd4) begin
      n_fail++;
      $display("FAIL midload_reach: State=%0d, need 4", State);
    end
    Reset = 1'b1;
    step();
    n_checks++;
    if (State !== 4'd0 || PC_Clr !== 1'b1 || RF_W_en !== 1'b0 || D_Addr !== 8'h00) begin
      n_fail++;
      $display("FAIL midload_reset: State=%0d PC_Clr=%b RF_W_en=%b D_Addr=%h, need 0 1 0 00",
               State, PC_Clr, RF_W_en, D_Addr);
    end
    Reset = 1'b0;
    step();
    n_checks++;
    if (State !== 4'd1) begin
      n_fail++;
      $display("FAIL midload_restart: State=%0d, need 1", State);
    end
    $display("reset during LOAD_A: back to INIT then FETCH");
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu(16'h3125, 4'd7, 3'd1, 4'd1, 4'd2, 4'd5);
    test_alu(16'h4321, 4'd8, 3'd2, 4'd3, 4'd2, 4'd1);
    test_store();
    test_noop();
    test_halt();
    test_illegal();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
